burst_pattern_gen: RTL and testbench

- Parametrised successor to the fixed-length counting-pattern header generator used for clustering-DB test data.
- Emits framed bursts of synthetic ADC-like words, selectable between ramp, constant, LFSR and walking-one patterns.
- Each frame carries a header word and start/end markers, plus an inter-frame gap, optional continuous repetition and downstream backpressure.
- Sits ahead of the clustering pipeline as a stimulus source for bring-up and loopback test.

---
 rtl/burst_pattern_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_burst_pattern_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/burst_pattern_gen.sv
// Framed burst pattern source: optional header word, BURST_LEN payload words
// (ramp / constant / LFSR / walking-one), then GAP_LEN idle cycles. It can
// repeat frames continuously and honours downstream backpressure.
//
// state | meaning
// IDLE  | no activity, data_out = IDLE_VAL, waiting for start
// HDR   | presenting the header word (frame_cnt), sof asserted
// DATA  | presenting payload word idx_q, eof on the last word
// GAP   | inter-frame idle, gap_q counts down to zero
module burst_pattern_gen #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       BURST_LEN = 48,
  parameter int unsigned       GAP_LEN   = 16,
  parameter logic [DATA_W-1:0] IDLE_VAL  = DATA_W'(200),
  parameter bit                HDR_EN    = 1'b1,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] ini_val,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              dv,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_LEN - 1);
  localparam logic        ONE_WORD = (BURST_LEN == 1);

  state_t            state, state_n;
  logic [1:0]        mode_q, mode_n;
  logic [DATA_W-1:0] ini_q, ini_n;
  logic [15:0]       idx_q, idx_n;
  logic [15:0]       gap_q, gap_n;
  logic [DATA_W-1:0] data_n;
  logic              dv_n, sof_n, eof_n;
  logic [15:0]       fcnt_n;
  logic              xfer;
  logic              launch;
  logic [1:0]        l_mode;
  logic [DATA_W-1:0] l_ini;
  logic [DATA_W-1:0] l_hdr;

  // Payload word 0 of a frame for the given pattern and seed.
  function automatic logic [DATA_W-1:0] first_word(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] seed);
    logic [DATA_W-1:0] w;
    int unsigned       sh;
    w  = seed;
    sh = 0;
    case (m)
      2'd2: if (seed == '0) w = DATA_W'(1);
      2'd3: begin
        sh = 32'(seed) % DATA_W;
        w  = DATA_W'(1) << sh;
      end
      default: w = seed;
    endcase
    return w;
  endfunction

  // Next payload word derived from the word currently on data_out.
  function automatic logic [DATA_W-1:0] next_word(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] n;
    n = w;
    case (m)
      2'd0: n = w + DATA_W'(1);
      2'd1: n = w;
      2'd2: begin
        n = w >> 1;
        if (w[0]) n = n ^ LFSR_TAPS;
      end
      default: n = {w[DATA_W-2:0], w[DATA_W-1]};
    endcase
    return n;
  endfunction

  assign xfer = dv & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next-state and next-output decode; abort overrides everything.
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    ini_n   = ini_q;
    idx_n   = idx_q;
    gap_n   = gap_q;
    data_n  = data_out;
    dv_n    = dv;
    sof_n   = sof;
    eof_n   = eof;
    fcnt_n  = frame_cnt;
    launch  = 1'b0;
    l_mode  = mode_q;
    l_ini   = ini_q;
    l_hdr   = DATA_W'(frame_cnt);

    if (abort) begin
      state_n = ST_IDLE;
      dv_n    = 1'b0;
      sof_n   = 1'b0;
      eof_n   = 1'b0;
      data_n  = IDLE_VAL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_n = mode;
            ini_n  = ini_val;
            l_mode = mode;
            l_ini  = ini_val;
            launch = 1'b1;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            state_n = ST_DATA;
            idx_n   = '0;
            sof_n   = 1'b0;
            eof_n   = ONE_WORD;
            data_n  = first_word(mode_q, ini_q);
          end
        end
        ST_DATA: begin
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
              fcnt_n = frame_cnt + 16'd1;
              dv_n   = 1'b0;
              sof_n  = 1'b0;
              eof_n  = 1'b0;
              data_n = IDLE_VAL;
              if (GAP_LEN > 0) begin
                state_n = ST_GAP;
                gap_n   = GAP_LOAD;
              end else if (cont) begin
                launch = 1'b1;
                l_hdr  = DATA_W'(frame_cnt + 16'd1);
              end else begin
                state_n = ST_IDLE;
              end
            end else begin
              idx_n  = idx_q + 16'd1;
              sof_n  = 1'b0;
              eof_n  = ((idx_q + 16'd1) == LAST_IDX);
              data_n = next_word(mode_q, data_out);
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            if (cont) launch = 1'b1;
            else      state_n = ST_IDLE;
          end else begin
            gap_n = gap_q - 16'd1;
          end
        end
        default: state_n = ST_IDLE;
      endcase

      if (launch) begin
        dv_n  = 1'b1;
        sof_n = 1'b1;
        if (HDR_EN) begin
          state_n = ST_HDR;
          eof_n   = 1'b0;
          data_n  = l_hdr;
        end else begin
          state_n = ST_DATA;
          idx_n   = '0;
          eof_n   = ONE_WORD;
          data_n  = first_word(l_mode, l_ini);
        end
      end
    end
  end

  // Registered outputs, latched configuration and the index/gap counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= '0;
      ini_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      data_out  <= IDLE_VAL;
      dv        <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      mode_q    <= mode_n;
      ini_q     <= ini_n;
      idx_q     <= idx_n;
      gap_q     <= gap_n;
      data_out  <= data_n;
      dv        <= dv_n;
      sof       <= sof_n;
      eof       <= eof_n;
      busy      <= (state_n != ST_IDLE);
      frame_cnt <= fcnt_n;
    end
  end

endmodule

// File: tb/tb_burst_pattern_gen.sv
// Bench for burst_pattern_gen with default parameters. Expected frames come
// from a per-word formula model; transfers are captured at the falling edge.
module tb_burst_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, cont, out_ready;
  logic [1:0] mode;
  logic [7:0] ini_val;
  logic [7:0] data_out;
  logic       dv, sof, eof, busy;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_fcnt = '0;

  burst_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cont      (cont),
    .mode      (mode),
    .ini_val   (ini_val),
    .out_ready (out_ready),
    .data_out  (data_out),
    .dv        (dv),
    .sof       (sof),
    .eof       (eof),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Payload word i of a frame, straight from the pattern definitions.
  function automatic logic [7:0] model_word(input int m, input logic [7:0] ini, input int i);
    logic [7:0] w;
    logic       lsb;
    case (m)
      0: w = 8'((int'(ini) + i) % 256);
      1: w = ini;
      2: begin
        w = (ini == 8'd0) ? 8'd1 : ini;
        for (int k = 0; k < i; k++) begin
          lsb = w[0];
          w   = w >> 1;
          if (lsb) w = w ^ 8'hB8;
        end
      end
      default: w = 8'(1 << ((int'(ini) + i) % 8));
    endcase
    return w;
  endfunction

  task automatic start_frame(input int m, input logic [7:0] ini, input logic c);
    mode    = 2'(m);
    ini_val = ini;
    cont    = c;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    mode    = 2'($urandom);
    ini_val = 8'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  // bp: 0 always ready, 1 random ready, 2 stall 3 cycles at payload index bp_idx.
  // Entered at a falling edge where the frame's first word is already shown.
  task automatic run_frame(input int m, input logic [7:0] ini, input int bp, input int bp_idx);
    logic [7:0] exp_w[$];
    logic [7:0] got_w[$];
    logic       got_s[$];
    logic       got_e[$];
    int   stall = 0;
    logic done  = 1'b0;
    logic r;
    logic pd = 1'b0, pr = 1'b1, ps = 1'b0, pe = 1'b0;
    logic [7:0] pdata = '0;
    exp_w.push_back(exp_fcnt[7:0]);
    for (int i = 0; i < 48; i++) exp_w.push_back(model_word(m, ini, i));
    chk("first_word_dv", {dv, sof}, 2'b11);
    for (int c = 0; c < 1000; c++) begin
      if (c > 0) @(negedge clk);
      if (pd && !pr) begin
        chk("hold_dv", dv, 1);
        chk("hold_data", data_out, pdata);
        chk("hold_flags", {sof, eof}, {ps, pe});
      end
      case (bp)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          r = !(dv && got_w.size() == 1 + bp_idx && stall < 3);
          if (!r) stall++;
        end
      endcase
      out_ready = r;
      if (dv && r) begin
        got_w.push_back(data_out);
        got_s.push_back(sof);
        got_e.push_back(eof);
        if (eof) done = 1'b1;
      end
      pd = dv; pr = r; pdata = data_out; ps = sof; pe = eof;
      if (done) break;
    end
    chk("frame_done", done, 1);
    exp_fcnt++;
    chk("frame_len", got_w.size(), 49);
    for (int i = 0; i < got_w.size() && i < 49; i++) begin
      chk($sformatf("word%0d", i), got_w[i], exp_w[i]);
      chk($sformatf("sof%0d", i), got_s[i], (i == 0));
      chk($sformatf("eof%0d", i), got_e[i], (i == 48));
    end
    if (bp == 2) chk("stall_cycles", stall, 3);
    out_ready = 1'b1;
  endtask

  task automatic wait_gap(input logic expect_cont);
    int   n = 0;
    logic ended = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) chk("frame_cnt", frame_cnt, exp_fcnt);
      if (dv || !busy) begin
        ended = 1'b1;
        break;
      end
      chk("gap_data", data_out, 8'd200);
      n++;
    end
    chk("gap_ended", ended, 1);
    chk("gap_len", n, 16);
    if (expect_cont) chk("cont_restart", {dv, sof, busy}, 3'b111);
    else             chk("idle_after", {dv, busy, data_out}, {2'b00, 8'd200});
  endtask

  initial begin
    logic [7:0] ini_r;
    int         m_r;
    int         xfer;
    rst = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
    mode = '0; ini_val = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dv", dv, 0);
    chk("rst_data", data_out, 8'd200);
    chk("rst_flags", {sof, eof}, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_fcnt", frame_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    start_frame(0, 8'd10, 1'b0);  run_frame(0, 8'd10, 0, 0);  wait_gap(1'b0);
    start_frame(0, 8'd250, 1'b0); run_frame(0, 8'd250, 0, 0); wait_gap(1'b0);
    start_frame(0, 8'd0, 1'b0);   run_frame(0, 8'd0, 2, 5);   wait_gap(1'b0);

    ini_r = 8'($urandom);
    start_frame(3, ini_r, 1'b1);
    run_frame(3, ini_r, 0, 0); wait_gap(1'b1);
    run_frame(3, ini_r, 1, 0); wait_gap(1'b1);
    cont = 1'b0;
    run_frame(3, ini_r, 0, 0); wait_gap(1'b0);

    start_frame(2, 8'd0, 1'b0); run_frame(2, 8'd0, 1, 0); wait_gap(1'b0);
    start_frame(3, 8'd6, 1'b0); run_frame(3, 8'd6, 1, 0); wait_gap(1'b0);

    for (int k = 0; k < 4; k++) begin
      m_r   = int'($urandom_range(0, 3));
      ini_r = 8'($urandom);
      start_frame(m_r, ini_r, 1'b0);
      run_frame(m_r, ini_r, 1, 0);
      wait_gap(1'b0);
    end

    // Abort at payload index 20, with a stray start pulse mid-frame.
    start_frame(0, 8'd0, 1'b0);
    xfer = 0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      start = (xfer == 10);
      if (xfer == 21) break;
      out_ready = 1'b1;
      if (dv) xfer++;
    end
    start = 1'b0;
    chk("abort_reached", xfer, 21);
    chk("pre_abort_word", data_out, 8'd20);
    out_ready = 1'b0;
    abort     = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_dv", dv, 0);
    chk("abort_data", data_out, 8'd200);
    chk("abort_flags", {sof, eof, busy}, 3'b000);
    chk("abort_fcnt", frame_cnt, exp_fcnt);

    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", {dv, busy}, 2'b00);
    out_ready = 1'b1;

    // Asynchronous reset mid-frame while stalled.
    start_frame(1, 8'h33, 1'b0);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_dv", dv, 0);
    chk("arst_data", data_out, 8'd200);
    chk("arst_busy", busy, 0);
    chk("arst_fcnt", frame_cnt, 0);
    exp_fcnt = '0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {dv, busy}, 2'b00);
    start_frame(1, 8'h33, 1'b0); run_frame(1, 8'h33, 0, 0); wait_gap(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
